phased_cache_ctrl: RTL and testbench
====================================

Name: phased_cache_ctrl

Overview:
- Controller for the 4-way, 4-set phased cache; sits directly above the four way instances.
- Phase 1 reads all four ways' tag/valid/dirty/counter outputs and resolves hit or victim. Phase 2 drives the data-array byte access on one way only.
- On a miss it writes back a dirty victim, fetches the line from memory, and fill-loads the victim way. It also drives the counter decrement strobes.

Parameters:
- WAYS, 4, number of ways (fixed 4; one-hot selects are 4 bits)
- FILL_CTR, 3'b111, counter value loaded into a freshly filled way

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller accepts request (IDLE only)
- req_rw  in  1  1=write byte, 0=read byte
- req_addr  in  32  {tag[31:6], index[5:4], offset[3:0]}
- req_wdata  in  8  write byte
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  request hit on first lookup
- resp_rdata  out  8  read byte (0 for writes)
- way_tag  in  104  4x26 tagOut, way0 in [25:0]
- way_valid  in  4  validOut per way
- way_dirty  in  4  dirtyOut per way
- way_ctr  in  12  4x3 ctrOut
- way_data  in  512  4x128 dataOut
- tag_o, index_o, index_dec_o, offset_o  out  26/2/4/4  lookup address fields to all ways
- cycle_en  out  1  data-phase enable
- rw  out  1  data-phase direction
- hit_way  out  4  one-hot selected way
- byte_o  out  8  write byte to data arrays
- dec  out  4  per-way counter decrement
- load  out  4  per-way fill load
- fill_tag  out  26  tag loaded on fill
- fill_line  out  128  line loaded on fill
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=writeback, 0=fetch
- mem_addr  out  32  line-aligned address ([3:0]=0)
- mem_wdata  out  128  victim line
- mem_ack  in  1  one-cycle completion
- mem_rdata  in  128  fetched line, valid with mem_ack

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0 except req_ready=1. Request register cleared.
- A reset asserted mid-operation aborts any memory transaction at once: mem_req drops and no load pulse is issued.
- States: IDLE, TAG, DATA, RESP, WB, FETCH, LOAD.
- IDLE: req_ready=1. When req_valid=1, register addr/rw/wdata and go to TAG. req_ready=0 in every other state.
- TAG: compare registered tag against all ways. A way matches when its tag is equal and its valid bit is 1.
  - Exactly one match: hit. Latch the one-hot way, resp_hit flag=1, go to DATA.
  - More than one match is illegal: assert with a simulation error, select the lowest index.
  - No match: miss, resp_hit flag=0. Victim = lowest-index invalid way. If all ways are valid, victim = lowest-index way with minimum ctr. Latch the victim.
  - Miss with victim dirty=1 and valid=1: go to WB. Otherwise go to FETCH.
- WB: mem_req=1, mem_we=1, mem_addr={victim tag, index, 4'b0}, mem_wdata=victim line. On mem_ack go to FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr={req tag, index, 4'b0}. On mem_ack, register mem_rdata into fill_line and go to LOAD.
- LOAD: load=victim one-hot for exactly 1 cycle, with fill_tag=req tag. The top level routes FILL_CTR, valid=1 and dirty=0 to the way's init inputs. Then go to DATA with hit_way=victim.
- DATA: cycle_en=1, rw=req_rw, hit_way=latched way, byte_o=req_wdata, for exactly 1 cycle.
  - dec[w]=1 for every way w != selected way with way_valid[w]=1 and ctr[w]!=0. There is never a decrement below 0.
  - Go to RESP.
- RESP: resp_valid=1 for 1 cycle. resp_rdata = byte offset of way_data[selected] (sampled in DATA) for reads, 0 for writes. resp_hit as latched. Then go to IDLE.
- Latency from acceptance edge:
  - Hit: resp_valid 3 cycles later.
  - Clean miss: 4 + fetch wait cycles.
  - Dirty miss: adds the writeback wait.
- index/tag/offset outputs hold the registered request from TAG through RESP.
- mem_req is never dropped before mem_ack. A mem_ack seen while mem_req=0 is ignored.
- Offset 15 selects bits [127:120]. Offset 0 selects bits [7:0].

Decomposition:
- Package cache_pkg holds:
  - state enum
  - TAG_W=26, IDX_W=2, OFF_W=4, LINE_W=128, CTR_W=3
  - address field slice functions
- One sub-module: victim_select. It is combinational, takes valid[3:0] and ctr[11:0], and returns a one-hot victim under the invalid-first, min-ctr, lowest-index rule.

Test Plan:
- Reset with all ways invalid; read addr 0x0000_0040 -> FETCH mem_addr=0x40. After mem_ack, load=4'b0001; resp_hit=0; resp_rdata = mem_rdata[7:0].
- Repeat the same read -> resp_valid 3 cycles after acceptance, resp_hit=1, hit_way=0001, no mem_req.
- Write 0xA5 to 0x0000_004F on a hit in way 2 -> cycle_en=1, rw=1, hit_way=0100, byte_o=0xA5. dec is asserted only on valid ways with ctr!=0 other than way 2.
- All ways valid, ctr={way0 3,way1 0,way2 0,way3 5}, way1 dirty, miss -> victim way1. WB mem_addr = way1 tag with index, mem_we=1. Then FETCH, then load=0010.
- Assert reset during FETCH with mem_req=1 -> mem_req=0 and req_ready=1 immediately. No load pulse after reset release.
- Delay mem_ack by 10 cycles -> mem_req and mem_addr held stable all 10 cycles. req_ready stays 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, field widths and address helpers for the 4-way phased cache controller.
package cache_pkg;

  localparam int TAG_W  = 26;
  localparam int IDX_W  = 2;
  localparam int OFF_W  = 4;
  localparam int LINE_W = 128;
  localparam int CTR_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG,
    ST_DATA,
    ST_RESP,
    ST_WB,
    ST_FETCH,
    ST_LOAD
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:6];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return addr[5:4];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [31:0] addr);
    return addr[3:0];
  endfunction

  // Keeps only the lowest set bit; all-zero input gives all-zero output.
  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/victim_select.sv
// Combinational victim choice: lowest invalid way first, otherwise lowest way holding the minimum counter.
module victim_select
  import cache_pkg::*;
(
  input  logic [3:0]  valid,
  input  logic [11:0] ctr,
  output logic [3:0]  victim
);

  logic [CTR_W-1:0] min_ctr;
  logic [3:0]       invalid_ways;
  logic [3:0]       min_ways;

  always_comb begin
    min_ctr = '1;
    for (int w = 0; w < 4; w++) begin
      if (ctr[w*CTR_W +: CTR_W] < min_ctr) begin
        min_ctr = ctr[w*CTR_W +: CTR_W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_way
      assign invalid_ways[gi] = ~valid[gi];
      assign min_ways[gi]     = (ctr[gi*CTR_W +: CTR_W] == min_ctr);
    end
  endgenerate

  assign victim = (|invalid_ways) ? lowest_one(invalid_ways) : lowest_one(min_ways);

endmodule

// File: rtl/phased_cache_ctrl.sv
// Phased cache controller: tag lookup, then single-way data access; misses write back a dirty victim,
// fetch the line and fill-load the victim way before the data phase.
module phased_cache_ctrl
  import cache_pkg::*;
#(
  parameter int         WAYS     = 4,
  parameter logic [2:0] FILL_CTR = 3'b111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rw,
  input  logic [31:0]   req_addr,
  input  logic [7:0]    req_wdata,
  output logic          resp_valid,
  output logic          resp_hit,
  output logic [7:0]    resp_rdata,
  input  logic [103:0]  way_tag,
  input  logic [3:0]    way_valid,
  input  logic [3:0]    way_dirty,
  input  logic [11:0]   way_ctr,
  input  logic [511:0]  way_data,
  output logic [25:0]   tag_o,
  output logic [1:0]    index_o,
  output logic [3:0]    index_dec_o,
  output logic [3:0]    offset_o,
  output logic          cycle_en,
  output logic          rw,
  output logic [3:0]    hit_way,
  output logic [7:0]    byte_o,
  output logic [3:0]    dec,
  output logic [3:0]    load,
  output logic [25:0]   fill_tag,
  output logic [127:0]  fill_line,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic          mem_ack,
  input  logic [127:0]  mem_rdata
);

  // One-hot selects are hard-wired to four ways; a zero fill counter would make new lines instant victims.
  if (WAYS != 4) begin : g_ways_chk
    $error("phased_cache_ctrl supports exactly 4 ways");
  end
  if (FILL_CTR == 3'b000) begin : g_fill_chk
    $error("FILL_CTR must be non-zero");
  end

  state_t state_reg, state_next;

  logic [TAG_W-1:0]  tag_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [OFF_W-1:0]  off_reg;
  logic              rw_reg;
  logic [7:0]        wdata_reg;
  logic [3:0]        way_sel_reg;
  logic              hit_flag_reg;
  logic [LINE_W-1:0] fill_line_reg;
  logic [7:0]        rdata_reg;

  logic [3:0]        match;
  logic [3:0]        dec_mask;
  logic [3:0]        victim;
  logic              victim_wb;
  logic              hit_any;
  logic [TAG_W-1:0]  sel_tag;
  logic [LINE_W-1:0] sel_line;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign match[gi]    = way_valid[gi] && (way_tag[gi*TAG_W +: TAG_W] == tag_reg);
      assign dec_mask[gi] = ~way_sel_reg[gi] & way_valid[gi] & (|way_ctr[gi*CTR_W +: CTR_W]);
    end
  endgenerate

  victim_select u_victim_select (
    .valid  (way_valid),
    .ctr    (way_ctr),
    .victim (victim)
  );

  assign hit_any   = |match;
  assign victim_wb = |(victim & way_valid & way_dirty);

  always_comb begin
    sel_tag  = '0;
    sel_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_sel_reg[w]) begin
        sel_tag  = sel_tag  | way_tag[w*TAG_W +: TAG_W];
        sel_line = sel_line | way_data[w*LINE_W +: LINE_W];
      end
    end
  end

  always @(posedge clk) begin
    if (reset && state_reg == ST_TAG) begin
      assert ($onehot0(match)) else $error("phased_cache_ctrl: tag matched in more than one way");
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_valid) state_next = ST_TAG;
      ST_TAG: begin
        if (hit_any)        state_next = ST_DATA;
        else if (victim_wb) state_next = ST_WB;
        else                state_next = ST_FETCH;
      end
      ST_WB:    if (mem_ack) state_next = ST_FETCH;
      ST_FETCH: if (mem_ack) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_DATA;
      ST_DATA:  state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_reg       <= '0;
      idx_reg       <= '0;
      off_reg       <= '0;
      rw_reg        <= 1'b0;
      wdata_reg     <= '0;
      way_sel_reg   <= '0;
      hit_flag_reg  <= 1'b0;
      fill_line_reg <= '0;
      rdata_reg     <= '0;
    end else begin
      if (state_reg == ST_IDLE && req_valid) begin
        tag_reg   <= addr_tag(req_addr);
        idx_reg   <= addr_idx(req_addr);
        off_reg   <= addr_off(req_addr);
        rw_reg    <= req_rw;
        wdata_reg <= req_wdata;
      end
      if (state_reg == ST_TAG) begin
        way_sel_reg  <= hit_any ? lowest_one(match) : victim;
        hit_flag_reg <= hit_any;
      end
      if (state_reg == ST_FETCH && mem_ack) begin
        fill_line_reg <= mem_rdata;
      end
      if (state_reg == ST_DATA) begin
        rdata_reg <= rw_reg ? 8'h00 : sel_line[{off_reg, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_rdata = '0;
    cycle_en   = 1'b0;
    rw         = 1'b0;
    hit_way    = '0;
    byte_o     = '0;
    dec        = '0;
    load       = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      ST_IDLE: req_ready = 1'b1;
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {sel_tag, idx_reg, 4'b0000};
        mem_wdata = sel_line;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = {tag_reg, idx_reg, 4'b0000};
      end
      ST_LOAD: load = way_sel_reg;
      ST_DATA: begin
        cycle_en = 1'b1;
        rw       = rw_reg;
        hit_way  = way_sel_reg;
        byte_o   = wdata_reg;
        dec      = dec_mask;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_flag_reg;
        resp_rdata = rdata_reg;
      end
      default: ;
    endcase
  end

  assign tag_o       = tag_reg;
  assign index_o     = idx_reg;
  assign offset_o    = off_reg;
  assign index_dec_o = (state_reg != ST_IDLE) ? (4'b0001 << idx_reg) : 4'b0000;
  assign fill_tag    = tag_reg;
  assign fill_line   = fill_line_reg;

endmodule

// File: tb/tb_phased_cache_ctrl.sv
// Directed bench for phased_cache_ctrl with a small behavioural model of the four way arrays.
module tb_phased_cache_ctrl;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rw = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [7:0]    req_wdata = '0;
  logic          resp_valid, resp_hit;
  logic [7:0]    resp_rdata;
  logic [103:0]  way_tag;
  logic [3:0]    way_valid, way_dirty;
  logic [11:0]   way_ctr;
  logic [511:0]  way_data;
  logic [25:0]   tag_o;
  logic [1:0]    index_o;
  logic [3:0]    index_dec_o, offset_o;
  logic          cycle_en, rw;
  logic [3:0]    hit_way, dec, load;
  logic [7:0]    byte_o;
  logic [25:0]   fill_tag;
  logic [127:0]  fill_line;
  logic          mem_req, mem_we;
  logic [31:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic          mem_ack = 1'b0;
  logic [127:0]  mem_rdata = '0;

  always #5 clk = ~clk;

  phased_cache_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .way_tag(way_tag), .way_valid(way_valid), .way_dirty(way_dirty),
    .way_ctr(way_ctr), .way_data(way_data),
    .tag_o(tag_o), .index_o(index_o), .index_dec_o(index_dec_o), .offset_o(offset_o),
    .cycle_en(cycle_en), .rw(rw), .hit_way(hit_way), .byte_o(byte_o),
    .dec(dec), .load(load), .fill_tag(fill_tag), .fill_line(fill_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Way array model, indexed [way][set]
  logic [25:0]  m_tag   [4][4];
  logic         m_valid [4][4];
  logic         m_dirty [4][4];
  logic [2:0]   m_ctr   [4][4];
  logic [127:0] m_data  [4][4];

  logic         clr_en = 1'b0, pre_en = 1'b0;
  int           pre_w = 0, pre_s = 0;
  logic [25:0]  pre_tag = '0;
  logic         pre_valid = 1'b0, pre_dirty = 1'b0;
  logic [2:0]   pre_ctr = '0;
  logic [127:0] pre_data = '0;

  always_comb begin
    way_tag = '0; way_valid = '0; way_dirty = '0; way_ctr = '0; way_data = '0;
    for (int w = 0; w < 4; w++) begin
      way_tag[w*26 +: 26]   = m_tag[w][index_o];
      way_valid[w]          = m_valid[w][index_o];
      way_dirty[w]          = m_dirty[w][index_o];
      way_ctr[w*3 +: 3]     = m_ctr[w][index_o];
      way_data[w*128 +: 128] = m_data[w][index_o];
    end
  end

  always @(posedge clk) begin
    if (clr_en) begin
      for (int w = 0; w < 4; w++) begin
        for (int s = 0; s < 4; s++) begin
          m_tag[w][s] <= '0; m_valid[w][s] <= 1'b0; m_dirty[w][s] <= 1'b0;
          m_ctr[w][s] <= '0; m_data[w][s] <= '0;
        end
      end
    end else if (pre_en) begin
      m_tag[pre_w][pre_s]   <= pre_tag;
      m_valid[pre_w][pre_s] <= pre_valid;
      m_dirty[pre_w][pre_s] <= pre_dirty;
      m_ctr[pre_w][pre_s]   <= pre_ctr;
      m_data[pre_w][pre_s]  <= pre_data;
    end else begin
      for (int w = 0; w < 4; w++) begin
        if (load[w]) begin
          m_tag[w][index_o]   <= fill_tag;
          m_valid[w][index_o] <= 1'b1;
          m_dirty[w][index_o] <= 1'b0;
          m_ctr[w][index_o]   <= 3'b111;
          m_data[w][index_o]  <= fill_line;
        end else begin
          if (cycle_en && rw && hit_way[w]) begin
            m_data[w][index_o][{offset_o, 3'b000} +: 8] <= byte_o;
            m_dirty[w][index_o] <= 1'b1;
          end
          if (dec[w] && m_ctr[w][index_o] != 3'd0)
            m_ctr[w][index_o] <= m_ctr[w][index_o] - 3'd1;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preset(input int w, input int s, input logic v, input logic d,
                        input logic [25:0] t, input logic [2:0] c, input logic [127:0] line);
    @(negedge clk);
    pre_w = w; pre_s = s; pre_valid = v; pre_dirty = d; pre_tag = t; pre_ctr = c; pre_data = line;
    pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Per-transaction captures
  int           r_lat, r_loads;
  logic         r_done, r_hit, r_wb, r_fetch, r_mem_stable, r_ready_low;
  logic [7:0]   r_rdata, r_byte;
  logic [3:0]   r_load, r_hit_way, r_dec, r_idx_dec;
  logic [31:0]  r_wb_addr, r_fetch_addr;
  logic [127:0] r_wb_data, r_fill_line;
  logic [25:0]  r_fill_tag, r_tag;
  logic         r_cyc, r_rw;

  task automatic run_req(input logic rw_i, input logic [31:0] addr_i, input logic [7:0] wd_i,
                         input logic [127:0] line_i, input int ack_dly);
    int cnt;
    logic [31:0] prev_addr;
    r_lat = -1; r_loads = 0; r_done = 0; r_hit = 0; r_wb = 0; r_fetch = 0;
    r_mem_stable = 1; r_ready_low = 1; r_rdata = 0; r_byte = 0; r_load = 0;
    r_hit_way = 0; r_dec = 0; r_idx_dec = 0; r_wb_addr = 0; r_fetch_addr = 0;
    r_wb_data = 0; r_fill_line = 0; r_fill_tag = 0; r_tag = 0; r_cyc = 0; r_rw = 0;
    cnt = 0; prev_addr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw_i; req_addr = addr_i; req_wdata = wd_i;
    chk("accept_ready", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 200 && !r_done; n++) begin
      @(negedge clk);
      if (req_ready) r_ready_low = 0;
      if (mem_ack) begin mem_ack = 1'b0; cnt = 0; end
      if (mem_req) begin
        if (mem_we) begin r_wb = 1; r_wb_addr = mem_addr; r_wb_data = mem_wdata; end
        else begin r_fetch = 1; r_fetch_addr = mem_addr; end
        if (cnt > 0 && mem_addr !== prev_addr) r_mem_stable = 0;
        prev_addr = mem_addr;
        if (cnt == ack_dly) begin mem_ack = 1'b1; mem_rdata = line_i; end
        else cnt++;
      end else if (cnt > 0) begin
        r_mem_stable = 0;
      end
      if (load != 4'b0) begin
        r_load = r_load | load; r_loads++; r_fill_tag = fill_tag; r_fill_line = fill_line;
      end
      if (cycle_en) begin
        r_cyc = 1; r_rw = rw; r_hit_way = hit_way; r_byte = byte_o; r_dec = dec;
        r_idx_dec = index_dec_o; r_tag = tag_o;
      end
      if (resp_valid) begin
        r_lat = n; r_hit = resp_hit; r_rdata = resp_rdata; r_done = 1;
      end
    end
    chk("resp_timeout", r_done, 1'b1);
    $display("req rw=%0d addr=%08h lat=%0d hit=%0d rdata=%02h load=%b dec=%b wb=%0d",
             rw_i, addr_i, r_lat, r_hit, r_rdata, r_load, r_dec, r_wb);
  endtask

  localparam logic [127:0] L1 = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E11;
  localparam logic [127:0] L4 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] V1 = 128'hDEADBEEF_00000000_00000000_CAFEF00D;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_load, saw_req;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clr_en = 1'b1;
    @(negedge clk);
    clr_en = 1'b0;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_outs", {cycle_en, load, dec, hit_way, mem_addr}, '0);
    reset = 1'b1;

    // Cold miss: way0 filled from memory
    run_req(1'b0, 32'h0000_0040, 8'h00, L1, 0);
    chk("s1_fetch_addr", r_fetch_addr, 32'h40);
    chk("s1_no_wb", r_wb, 1'b0);
    chk("s1_load", r_load, 4'b0001);
    chk("s1_load_cnt", r_loads, 1);
    chk("s1_fill_tag", r_fill_tag, 26'h1);
    chk("s1_fill_line", r_fill_line, L1);
    chk("s1_hit", r_hit, 1'b0);
    chk("s1_rdata", r_rdata, 8'h11);
    chk("s1_lat", r_lat, 5);

    // Same read hits
    run_req(1'b0, 32'h0000_0040, 8'h00, L1, 0);
    chk("s2_lat", r_lat, 3);
    chk("s2_hit", r_hit, 1'b1);
    chk("s2_hit_way", r_hit_way, 4'b0001);
    chk("s2_no_mem", {r_wb, r_fetch}, 2'b00);
    chk("s2_rdata", r_rdata, 8'h11);
    chk("s2_dec", r_dec, 4'b0000);

    // Write hit in way2; way3 holds the same tag but is invalid
    preset(0, 0, 1'b1, 1'b0, 26'h5, 3'd3, 128'h0);
    preset(1, 0, 1'b1, 1'b0, 26'h6, 3'd0, 128'h0);
    preset(2, 0, 1'b1, 1'b0, 26'h1, 3'd4, 128'h0);
    preset(3, 0, 1'b0, 1'b0, 26'h1, 3'd2, 128'h0);
    run_req(1'b1, 32'h0000_004F, 8'hA5, 128'h0, 0);
    chk("s3_cyc_rw", {r_cyc, r_rw}, 2'b11);
    chk("s3_hit_way", r_hit_way, 4'b0100);
    chk("s3_byte", r_byte, 8'hA5);
    chk("s3_dec", r_dec, 4'b0001);
    chk("s3_idx_dec", r_idx_dec, 4'b0001);
    chk("s3_tag_o", r_tag, 26'h1);
    chk("s3_rdata_wr", r_rdata, 8'h00);
    chk("s3_hit", r_hit, 1'b1);
    chk("s3_lat", r_lat, 3);
    run_req(1'b0, 32'h0000_004F, 8'h00, 128'h0, 0);
    chk("s3_rd_off15", r_rdata, 8'hA5);
    chk("s3_rd_rw", r_rw, 1'b0);

    // Full set, min ctr tie between way1/way2, way1 dirty -> writeback
    preset(0, 1, 1'b1, 1'b0, 26'h10, 3'd3, 128'h0);
    preset(1, 1, 1'b1, 1'b1, 26'h11, 3'd0, V1);
    preset(2, 1, 1'b1, 1'b0, 26'h12, 3'd0, 128'h0);
    preset(3, 1, 1'b1, 1'b0, 26'h13, 3'd5, 128'h0);
    run_req(1'b0, 32'h0000_0812, 8'h00, L4, 0);
    chk("s4_wb", r_wb, 1'b1);
    chk("s4_wb_addr", r_wb_addr, 32'h450);
    chk("s4_wb_data", r_wb_data, V1);
    chk("s4_fetch_addr", r_fetch_addr, 32'h810);
    chk("s4_load", r_load, 4'b0010);
    chk("s4_fill_tag", r_fill_tag, 26'h20);
    chk("s4_dec", r_dec, 4'b1001);
    chk("s4_rdata", r_rdata, 8'hD2);
    chk("s4_hit", r_hit, 1'b0);
    chk("s4_lat", r_lat, 6);

    // Reset during FETCH aborts the memory request
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0000_0C20; req_wdata = 8'h00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    saw_req = 1'b0;
    for (int n = 0; n < 10 && !saw_req; n++) begin
      @(negedge clk);
      if (mem_req) saw_req = 1'b1;
    end
    chk("s5_fetch_req", {saw_req, mem_we}, 2'b10);
    #2 reset = 1'b0;
    #1;
    chk("s5_rst_mem_req", mem_req, 1'b0);
    chk("s5_rst_ready", req_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    saw_load = 1'b0; saw_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (load != 4'b0) saw_load = 1'b1;
      if (mem_req) saw_req = 1'b1;
    end
    chk("s5_no_load", saw_load, 1'b0);
    chk("s5_no_req", saw_req, 1'b0);
    $display("reset during fetch load_seen=%0d req_seen=%0d", saw_load, saw_req);

    // Slow memory: ack after 10 waiting cycles
    run_req(1'b0, 32'h0000_01F0, 8'h00, L1, 10);
    chk("s6_fetch_addr", r_fetch_addr, 32'h1F0);
    chk("s6_stable", r_mem_stable, 1'b1);
    chk("s6_ready_low", r_ready_low, 1'b1);
    chk("s6_lat", r_lat, 15);
    chk("s6_rdata", r_rdata, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
